// File: rtl/tus_pkg.sv
// Shared definitions for the push-button reader: event codes, key FSM states
// and default timing for a 27 MHz clock.
package tus_pkg;

  localparam int CLK_HZ            = 27_000_000;
  localparam int DEF_DEB_CYCLES    = CLK_HZ / 50;
  localparam int DEF_LONG_CYCLES   = CLK_HZ;
  localparam int DEF_REPEAT_CYCLES = CLK_HZ / 5;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;
  localparam logic [1:0] EVT_REPEAT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } key_fsm_t;

  // Bits needed to hold values 0..v, never less than one.
  function automatic int cnt_w(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/tus_okuyucu_if.sv
// Event stream from the button reader to its consumer (valid/ready).
interface tus_okuyucu_if #(
  parameter int KEY_W = 1
) ();
  logic             evt_valid;
  logic             evt_ready;
  logic [KEY_W-1:0] evt_key;
  logic [1:0]       evt_type;

  modport master (output evt_valid, output evt_key, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_type, output evt_ready);
endinterface

// File: rtl/tus_kanali.sv
// One button channel: synchroniser, debouncer, press/long/repeat FSM and a
// single-entry pending event slot.
module tus_kanali
  import tus_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic       take,
  output logic       level,
  output logic       pend_v,
  output logic [1:0] pend_t,
  output logic       ovf
);

  localparam int DW = cnt_w(DEB_CYCLES);
  localparam int HW = cnt_w((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES);
  localparam bit LONG_EN = (LONG_CYCLES > 0);
  localparam bit REP_EN  = LONG_EN && (REPEAT_CYCLES > 0);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic          sync1_r, sync2_r, lvl_s;
  logic          key_state_r;
  logic [DW-1:0] deb_cnt_r;
  logic          toggle_s, rise_s, fall_s;
  key_fsm_t      state_r, state_s;
  logic [HW-1:0] hold_cnt_r, hold_cnt_s;
  logic          evt_s;
  logic [1:0]    evt_t_s;
  logic          pend_v_r;
  logic [1:0]    pend_t_r;

  // Debounced edge detection: the edge where the counter would reach DEB_CYCLES.
  always_comb begin
    lvl_s    = ~sync2_r;
    toggle_s = (lvl_s != key_state_r) && (deb_cnt_r == DEB_LAST);
    rise_s   = toggle_s && lvl_s;
    fall_s   = toggle_s && !lvl_s;
  end

  // Key FSM next state, hold counter and event generation; release wins over thresholds.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    evt_s      = 1'b0;
    evt_t_s    = EVT_PRESS;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_s    = PRESSED;
          hold_cnt_s = '0;
          evt_s      = 1'b1;
          evt_t_s    = EVT_PRESS;
        end else begin
          hold_cnt_s = '0;
        end
      end
      PRESSED: begin
        if (fall_s) begin
          state_s    = IDLE;
          hold_cnt_s = '0;
          evt_s      = 1'b1;
          evt_t_s    = EVT_RELEASE;
        end else if (LONG_EN && (hold_cnt_r == LONG_LAST)) begin
          state_s    = LONG_HELD;
          hold_cnt_s = '0;
          evt_s      = 1'b1;
          evt_t_s    = EVT_LONG;
        end else if (LONG_EN) begin
          hold_cnt_s = hold_cnt_r + HW'(1);
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      LONG_HELD: begin
        if (fall_s) begin
          state_s    = IDLE;
          hold_cnt_s = '0;
          evt_s      = 1'b1;
          evt_t_s    = EVT_RELEASE;
        end else if (REP_EN && (hold_cnt_r == REP_LAST)) begin
          hold_cnt_s = '0;
          evt_s      = 1'b1;
          evt_t_s    = EVT_REPEAT;
        end else if (REP_EN) begin
          hold_cnt_s = hold_cnt_r + HW'(1);
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      default: begin
        state_s    = IDLE;
        hold_cnt_s = '0;
      end
    endcase
  end

  // Synchroniser, debounce counter, FSM state and pending slot registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r     <= 1'b1;
      sync2_r     <= 1'b1;
      key_state_r <= 1'b0;
      deb_cnt_r   <= '0;
      state_r     <= IDLE;
      hold_cnt_r  <= '0;
      pend_v_r    <= 1'b0;
      pend_t_r    <= EVT_PRESS;
    end else begin
      sync1_r    <= key_n;
      sync2_r    <= sync1_r;
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      if (toggle_s) begin
        key_state_r <= lvl_s;
        deb_cnt_r   <= '0;
      end else if (lvl_s != key_state_r) begin
        deb_cnt_r <= deb_cnt_r + DW'(1);
      end else begin
        deb_cnt_r <= '0;
      end
      // A new event always lands; if it is also being taken now it simply refills.
      if (evt_s) begin
        pend_v_r <= 1'b1;
        pend_t_r <= evt_t_s;
      end else if (take) begin
        pend_v_r <= 1'b0;
      end else begin
        pend_v_r <= pend_v_r;
      end
    end
  end

  assign level  = key_state_r;
  assign pend_v = pend_v_r;
  assign pend_t = pend_t_r;
  assign ovf    = evt_s && pend_v_r && !take;

endmodule

// File: rtl/tus_okuyucu.sv
// Push-button reader: N debounced key channels, lowest-index arbiter,
// registered event output with valid/ready and a sticky overflow flag.
module tus_okuyucu
  import tus_pkg::*;
#(
  parameter int N_KEYS        = 2,
  parameter int KEY_W         = 1,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] keys_n,
  output logic [N_KEYS-1:0] key_state,
  tus_okuyucu_if.master     evt,
  output logic              evt_ovf,
  input  logic              ovf_clr
);

  logic [N_KEYS-1:0] pend_v_s;
  logic [1:0]        pend_t_s [N_KEYS];
  logic [N_KEYS-1:0] take_s;
  logic [N_KEYS-1:0] ovf_s;
  logic              any_s;
  logic [KEY_W-1:0]  ld_key_s;
  logic [1:0]        ld_type_s;

  logic              out_valid_r;
  logic [KEY_W-1:0]  out_key_r;
  logic [1:0]        out_type_r;
  logic              evt_ovf_r;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    tus_kanali #(
      .DEB_CYCLES    (DEB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_n  (keys_n[g]),
      .take   (take_s[g]),
      .level  (key_state[g]),
      .pend_v (pend_v_s[g]),
      .pend_t (pend_t_s[g]),
      .ovf    (ovf_s[g])
    );
  end

  // Fixed-priority pick of the lowest pending key; it is taken only while the output is empty.
  always_comb begin
    take_s    = '0;
    any_s     = 1'b0;
    ld_key_s  = '0;
    ld_type_s = EVT_PRESS;
    for (int i = 0; i < N_KEYS; i++) begin
      if (!any_s && pend_v_s[i]) begin
        any_s     = 1'b1;
        take_s[i] = !out_valid_r;
        ld_key_s  = KEY_W'(i);
        ld_type_s = pend_t_s[i];
      end else begin
        take_s[i] = 1'b0;
      end
    end
  end

  // Output register; loading only when empty gives the idle cycle after each accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_key_r   <= '0;
      out_type_r  <= EVT_PRESS;
    end else if (out_valid_r) begin
      if (evt.evt_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= 1'b1;
      end
    end else if (any_s) begin
      out_valid_r <= 1'b1;
      out_key_r   <= ld_key_s;
      out_type_r  <= ld_type_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky overflow flag; a new loss beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_ovf_r <= 1'b0;
    end else if (|ovf_s) begin
      evt_ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      evt_ovf_r <= 1'b0;
    end else begin
      evt_ovf_r <= evt_ovf_r;
    end
  end

  assign evt.evt_valid = out_valid_r;
  assign evt.evt_key   = out_key_r;
  assign evt.evt_type  = out_type_r;
  assign evt_ovf       = evt_ovf_r;

endmodule
